// File: rtl/button_bank.sv
// Multi-channel push-button conditioner: sync, debounce, edge and long-press pulses.
// Optional auto-repeat of press_pulse while held: define BUTTON_BANK_REPEAT_EN.
module button_bank #(
    parameter int N_BTN          = 4,
    parameter int SAMPLE_DIV     = 100000,
    parameter int DB_SAMPLES     = 4,
    parameter int HOLD_SAMPLES   = 1000,
    parameter int REPEAT_SAMPLES = 200
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb_in,
    output logic [N_BTN-1:0] pb_level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic             tick
);

    localparam int DIVW = $clog2(SAMPLE_DIV);
    localparam int DBW  = $clog2(DB_SAMPLES + 1);
    localparam int HW   = $clog2(HOLD_SAMPLES + 1);

    localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(SAMPLE_DIV - 1);
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DB_SAMPLES - 1);
    localparam logic [HW-1:0]   HOLD_MAX  = HW'(HOLD_SAMPLES);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_SAMPLES - 1);

`ifdef BUTTON_BANK_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SAMPLES + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SAMPLES - 1);
`endif

    logic [DIVW-1:0]  div_cnt;
    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] pb_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIVW'(1);
        end
    end

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            pb_s  <= '0;
        end else begin
            sync1 <= pb_in;
            pb_s  <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic          level_q;
        logic          press_q;
        logic          rel_q;
        logic          long_q;
        logic [DBW-1:0] db_cnt;
        logic [HW-1:0]  hold_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                level_q  <= 1'b0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                db_cnt   <= '0;
                hold_cnt <= '0;
            end else begin
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                long_q  <= 1'b0;
                if (tick) begin
                    if (pb_s[i] == level_q) begin
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        level_q <= ~level_q;
                        db_cnt  <= '0;
                        press_q <= ~level_q;
                        rel_q   <= level_q;
                    end else begin
                        db_cnt <= db_cnt + DBW'(1);
                    end
                end
                // The press tick sees level 0, so it leaves hold_cnt at 0.
                if (!level_q) begin
                    hold_cnt <= '0;
                end else if (tick && hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + HW'(1);
                    long_q   <= (hold_cnt == HOLD_LAST);
                end
`ifdef BUTTON_BANK_REPEAT_EN
`endif
            end
        end

`ifdef BUTTON_BANK_REPEAT_EN
        logic [RW-1:0] rep_cnt;
        logic          rep_q;

        // Repeat counting starts on the first tick after long_pulse.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rep_cnt <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                if (!level_q) begin
                    rep_cnt <= '0;
                end else if (tick && hold_cnt == HOLD_MAX) begin
                    if (rep_cnt == REP_LAST) begin
                        rep_cnt <= '0;
                        rep_q   <= 1'b1;
                    end else begin
                        rep_cnt <= rep_cnt + RW'(1);
                    end
                end
            end
        end

        assign press_pulse[i] = press_q | rep_q;
`else
        assign press_pulse[i] = press_q;
`endif

        assign pb_level[i]      = level_q;
        assign release_pulse[i] = rel_q;
        assign long_pulse[i]    = long_q;
    end

endmodule

// File: tb/tb_button_bank.sv
// Randomised and directed bench for button_bank against a tick-level model.
// Model counts held ticks directly; repeats derived arithmetically.
module tb_button_bank;

    localparam int N    = 2;
    localparam int DIV  = 4;
    localparam int DB   = 3;
    localparam int HOLD = 10;
    localparam int REP  = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pb_in = '0;
    logic [N-1:0] pb_level, press_pulse, release_pulse, long_pulse;
    logic         tick;

    int vectors = 0;
    int miscompares = 0;

    button_bank #(
        .N_BTN(N), .SAMPLE_DIV(DIV), .DB_SAMPLES(DB),
        .HOLD_SAMPLES(HOLD), .REPEAT_SAMPLES(REP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_in(pb_in),
        .pb_level(pb_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .long_pulse(long_pulse),
        .tick(tick)
    );

    always #5 clk = ~clk;

    // Reference model
    int           cyc = 0;
    logic [N-1:0] s1m = '0, s2m = '0, samp = '0;
    logic [N-1:0] lvl = '0, e_press = '0, e_rel = '0, e_long = '0;
    logic         e_tick = 1'b0, tk = 1'b0;
    int           run [N];
    int           held [N];
    logic [4*N:0] exp_v, dut_v;

    assign exp_v = {lvl, e_press, e_rel, e_long, e_tick};
    assign dut_v = {pb_level, press_pulse, release_pulse, long_pulse, tick};

    initial begin
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            held[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0; s1m = '0; s2m = '0; lvl = '0;
                e_press = '0; e_rel = '0; e_long = '0; e_tick = 1'b0;
                for (int i = 0; i < N; i++) begin
                    run[i] = 0;
                    held[i] = 0;
                end
            end else begin
                samp = s2m; s2m = s1m; s1m = pb_in;
                tk = ((cyc % DIV) == DIV - 1);
                cyc++;
                e_press = '0; e_rel = '0; e_long = '0;
                if (tk) begin
                    for (int i = 0; i < N; i++) begin
                        if (lvl[i]) begin
                            held[i]++;
                            if (held[i] == HOLD) e_long[i] = 1'b1;
`ifdef BUTTON_BANK_REPEAT_EN
                            if (held[i] > HOLD && (held[i] - HOLD) % REP == 0)
                                e_press[i] = 1'b1;
`endif
                        end else begin
                            held[i] = 0;
                        end
                        if (samp[i] == lvl[i]) begin
                            run[i] = 0;
                        end else begin
                            run[i]++;
                            if (run[i] == DB) begin
                                run[i] = 0;
                                lvl[i] = ~lvl[i];
                                if (lvl[i]) e_press[i] = 1'b1;
                                else e_rel[i] = 1'b1;
                            end
                        end
                    end
                end
                e_tick = ((cyc % DIV) == DIV - 1);
            end
        end
    end

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        pb_in = 2'b11;
        repeat (5) @(negedge clk);
        vectors++;
        if (dut_v !== '0) begin
            miscompares++;
            $display("FAIL reset_hold got=%b exp=0", dut_v);
        end
        rst_n = 1'b1;
        k = 0;
        for (int c = 1; c <= 40 && k == 0; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL reset_cyc t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            if (press_pulse != 0) begin
                k = c;
                vectors++;
                if (press_pulse !== 2'b11) begin
                    miscompares++;
                    $display("FAIL reset_press_both got=%b exp=11", press_pulse);
                end
            end
        end
        vectors++;
        if (k != 3 * DIV) begin
            miscompares++;
            $display("FAIL reset_press_latency got=%0d exp=%0d", k, 3 * DIV);
        end
    endtask

    task automatic test_bounce();
        int np, nr;
        pb_in = 2'b00;
        repeat (30) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_pre t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
        end
        np = 0; nr = 0;
        for (int c = 0; c < 60; c++) begin
            if (c % 5 == 0) pb_in[0] = ~pb_in[0];
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL bounce_cyc t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            np += int'(press_pulse[0]);
            nr += int'(release_pulse[0]);
        end
        vectors++;
        if (np + nr != 0) begin
            miscompares++;
            $display("FAIL bounce_pulses got=%0d exp=0", np + nr);
        end
        pb_in[0] = 1'b1;
        np = 0;
        repeat (28) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL settle_cyc t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            np += int'(press_pulse[0]);
        end
        vectors++;
        if (np != 1 || pb_level[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL settle_press got=%0d/%b exp=1/1", np, pb_level[0]);
        end
    endtask

    task automatic test_release();
        int nr, nl;
        pb_in[0] = 1'b0;
        nr = 0; nl = 0;
        repeat (30) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL release_cyc t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            nr += int'(release_pulse[0]);
            nl += int'(long_pulse[0]);
        end
        vectors++;
        if (nr != 1 || nl != 0 || pb_level[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL release_counts got=%0d,%0d exp=1,0", nr, nl);
        end
    endtask

    task automatic test_long_press();
        int np, nl, ts, long_at, exp_np;
        bit seen;
        pb_in[1] = 1'b1;
        seen = 0; np = 0; nl = 0; ts = 0; long_at = -1;
        for (int c = 0; c < 400 && ts < 60; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL long_cyc t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            if (press_pulse[1]) begin
                seen = 1;
                np++;
            end
            if (long_pulse[1]) begin
                nl++;
                long_at = ts;
            end
            if (seen && tick) ts++;
        end
        repeat (2) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL long_tail t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            np += int'(press_pulse[1]);
        end
`ifdef BUTTON_BANK_REPEAT_EN
        exp_np = 1 + (60 - HOLD) / REP;
`else
        exp_np = 1;
`endif
        vectors++;
        if (nl != 1 || long_at != HOLD) begin
            miscompares++;
            $display("FAIL long_once got=%0d@%0d exp=1@%0d", nl, long_at, HOLD);
        end
        vectors++;
        if (np != exp_np) begin
            miscompares++;
            $display("FAIL long_press_cnt got=%0d exp=%0d", np, exp_np);
        end
        pb_in[1] = 1'b0;
        np = 0;
        repeat (40) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL long_rel t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            np += int'(press_pulse[1]);
        end
        vectors++;
        if (np != 0 || pb_level[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL long_after_release got=%0d exp=0", np);
        end
    endtask

    task automatic test_mid_reset();
        int ts, k, long_at;
        bit seen;
        pb_in[0] = 1'b1;
        seen = 0; ts = 0;
        for (int c = 0; c < 200 && ts < 7; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL mid_pre t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            if (press_pulse[0]) seen = 1;
            if (seen && tick) ts++;
        end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if (dut_v !== '0) begin
            miscompares++;
            $display("FAIL mid_async_clear got=%b exp=0", dut_v);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0; ts = 0; long_at = -1; seen = 0;
        for (int c = 1; c <= 200 && long_at < 0; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL mid_post t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            if (press_pulse[0] && !seen) begin
                seen = 1;
                k = c;
            end
            if (long_pulse[0]) long_at = ts;
            if (seen && tick) ts++;
        end
        vectors++;
        if (k != 3 * DIV || long_at != HOLD) begin
            miscompares++;
            $display("FAIL mid_fresh got=%0d,%0d exp=%0d,%0d", k, long_at, 3 * DIV, HOLD);
        end
        pb_in = '0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            vectors++;
            if (dut_v !== exp_v) begin
                miscompares++;
                $display("FAIL random t=%0t got=%b exp=%b", $time, dut_v, exp_v);
            end
            if ($urandom_range(0, 5) == 0)
                pb_in[$urandom_range(0, N - 1)] ^= 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_release();
        test_long_press();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
